// File: rtl/cb_seg_pkg.sv
// Shared types and constants for the code block segmentation engine.
// Includes the bytewise CRC-24 step used by the CB CRC register.
package cb_seg_pkg;

    localparam int CRC_W = 24;
    localparam logic [CRC_W-1:0] CRC24A_POLY = 24'h864CFB;
    localparam logic [CRC_W-1:0] CRC24B_POLY = 24'h800063;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        FILL,
        DATA,
        CRC
    } state_e;

    function automatic logic [CRC_W-1:0] crc24_byte(
        input logic [CRC_W-1:0] c,
        input logic [7:0]       d,
        input logic [CRC_W-1:0] poly
    );
        logic [CRC_W-1:0] r;
        logic             fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[CRC_W-1] ^ d[i];
            r  = {r[CRC_W-2:0], 1'b0};
            if (fb) r = r ^ poly;
        end
        return r;
    endfunction

endpackage

// File: rtl/cb_seg_stream_crc.sv
// Registered 24-bit CRC, one byte per enabled cycle, MSB first, init 0.
// Clear has priority over update so the final byte of a CB restarts it.
module cb_crc_byte
    import cb_seg_pkg::*;
#(
    parameter logic [CRC_W-1:0] POLY = CRC24B_POLY
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [7:0]       d,
    output logic [CRC_W-1:0] crc
);

    logic [CRC_W-1:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr)     crc_d = '0;
        else if (en) crc_d = crc24_byte(crc_q, d, POLY);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) crc_q <= '0;
        else       crc_q <= crc_d;
    end

    assign crc = crc_q;

endmodule

// File: rtl/cb_seg_stream.sv
// Code block segmentation: splits a TB into C CBs with head filler and
// per-CB CRC, broadcasting the byte stream to N_OUT consumers.
module cb_seg_stream
    import cb_seg_pkg::*;
#(
    parameter int               K_BYTES  = 768,
    parameter int               SIZE_W   = 12,
    parameter int               N_OUT    = 2,
    parameter logic [CRC_W-1:0] CRC_POLY = CRC24B_POLY,
    parameter int               CNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SIZE_W-1:0] size_in,
    input  logic              size_valid,
    output logic              size_ready,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [7:0]        m_data,
    output logic              m_start,
    output logic              m_last,
    output logic              m_filler,
    output logic              m_crc,
    output logic [CNT_W-1:0]  m_cb_idx,
    output logic              m_valid,
    input  logic [N_OUT-1:0]  m_ready,
    output logic [CNT_W-1:0]  cb_count,
    output logic              busy,
    output logic              err
);

    localparam logic [SIZE_W-1:0] L     = SIZE_W'(K_BYTES - 3);
    localparam logic [CNT_W-1:0]  C_MAX = '1;

    state_e            state_q;
    logic [SIZE_W-1:0] rem_q, b_q, f_q, cnt_q;
    logic [CNT_W-1:0]  c_q, idx_q, cb_count_q;
    logic              err_q, rdy_q;

    logic              xfer;
    logic [SIZE_W-1:0] dlen;
    logic [CRC_W-1:0]  crc;

    assign xfer = m_valid && (&m_ready);
    assign dlen = (cb_count_q == CNT_W'(1)) ? b_q
                : (idx_q == '0) ? L - f_q : L;

    always_comb begin
        m_valid  = 1'b0;
        m_data   = 8'h00;
        m_start  = 1'b0;
        m_last   = 1'b0;
        m_filler = 1'b0;
        m_crc    = 1'b0;
        unique case (state_q)
            FILL: begin
                m_valid  = 1'b1;
                m_filler = 1'b1;
                m_start  = (cnt_q == '0);
            end
            DATA: begin
                m_valid = s_valid;
                m_data  = s_data;
                // CB0 with filler already flagged its start in FILL
                m_start = (cnt_q == '0) && !((idx_q == '0) && (f_q != '0));
                m_last  = (cb_count_q == CNT_W'(1)) && (cnt_q == dlen - 1'b1);
            end
            CRC: begin
                m_valid = 1'b1;
                m_crc   = 1'b1;
                m_last  = (cnt_q == SIZE_W'(2));
                if (cnt_q == '0)              m_data = crc[23:16];
                else if (cnt_q == SIZE_W'(1)) m_data = crc[15:8];
                else                          m_data = crc[7:0];
            end
            default: ;
        endcase
    end

    assign s_ready    = (state_q == DATA) && s_valid && (&m_ready);
    assign size_ready = rdy_q;
    assign m_cb_idx   = idx_q;
    assign cb_count   = cb_count_q;
    assign busy       = (state_q != IDLE);
    assign err        = err_q;

    cb_crc_byte #(.POLY(CRC_POLY)) u_crc (
        .clk   (clk),
        .reset (reset),
        .clr   (xfer && m_last),
        .en    (xfer && (state_q == FILL || state_q == DATA)),
        .d     (m_data),
        .crc   (crc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            b_q        <= '0;
            f_q        <= '0;
            cnt_q      <= '0;
            c_q        <= '0;
            idx_q      <= '0;
            cb_count_q <= '0;
            err_q      <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    rdy_q <= 1'b1;
                    if (size_valid && rdy_q) begin
                        if (size_in == '0) begin
                            err_q <= 1'b1;
                        end else begin
                            rdy_q      <= 1'b0;
                            rem_q      <= size_in;
                            b_q        <= size_in;
                            c_q        <= CNT_W'(1);
                            idx_q      <= '0;
                            cnt_q      <= '0;
                            cb_count_q <= '0;
                            state_q    <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (rem_q > L) begin
                        if (c_q == C_MAX) begin
                            err_q   <= 1'b1;
                            rdy_q   <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            rem_q <= rem_q - L;
                            c_q   <= c_q + 1'b1;
                        end
                    end else begin
                        cb_count_q <= c_q;
                        f_q        <= (c_q == CNT_W'(1)) ? '0 : L - rem_q;
                        if ((c_q != CNT_W'(1)) && (rem_q != L)) state_q <= FILL;
                        else                                    state_q <= DATA;
                    end
                end
                FILL: if (xfer) begin
                    if (cnt_q == f_q - 1'b1) begin
                        cnt_q   <= '0;
                        state_q <= DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: if (xfer) begin
                    if (cnt_q == dlen - 1'b1) begin
                        cnt_q <= '0;
                        if (cb_count_q == CNT_W'(1)) begin
                            rdy_q   <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            state_q <= CRC;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                CRC: if (xfer) begin
                    if (cnt_q == SIZE_W'(2)) begin
                        cnt_q <= '0;
                        if (idx_q == cb_count_q - 1'b1) begin
                            idx_q   <= '0;
                            rdy_q   <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cb_seg_stream.sv
// Bench for cb_seg_stream with K_BYTES=16: random TB bytes and stalls
// checked against a segmentation/CRC reference built from arithmetic.
module tb_cb_seg_stream;

    localparam int K  = 16;
    localparam int L  = K - 3;
    localparam int SW = 12;
    localparam int CW = 8;
    localparam int NO = 2;

    typedef logic [7:0] bq_t[$];

    logic          clk = 1'b0;
    logic          reset;
    logic [SW-1:0] size_in;
    logic          size_valid;
    logic          size_ready;
    logic [7:0]    s_data;
    logic          s_valid;
    logic          s_ready;
    logic [7:0]    m_data;
    logic          m_start, m_last, m_filler, m_crc, m_valid;
    logic [CW-1:0] m_cb_idx;
    logic [NO-1:0] m_ready;
    logic [CW-1:0] cb_count;
    logic          busy, err;

    int errors = 0;
    int checks = 0;

    bq_t         src;
    logic [19:0] exp_q[$];
    logic [19:0] got_q[$];

    always #5 clk = ~clk;

    cb_seg_stream #(
        .K_BYTES (K),
        .SIZE_W  (SW),
        .N_OUT   (NO),
        .CRC_POLY(24'h800063),
        .CNT_W   (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .size_in   (size_in),
        .size_valid(size_valid),
        .size_ready(size_ready),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .m_data    (m_data),
        .m_start   (m_start),
        .m_last    (m_last),
        .m_filler  (m_filler),
        .m_crc     (m_crc),
        .m_cb_idx  (m_cb_idx),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .cb_count  (cb_count),
        .busy      (busy),
        .err       (err)
    );

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Remainder of M(x)*x^24 divided by the generator, by long division
    function automatic logic [23:0] ref_crc(input bq_t msg);
        logic [24:0] r;
        r = '0;
        for (int i = 0; i < msg.size() * 8 + 24; i++) begin
            r = {r[23:0], (i < msg.size() * 8) ? msg[i / 8][7 - i % 8] : 1'b0};
            if (r[24]) r = r ^ 25'h1800063;
        end
        return r[23:0];
    endfunction

    function automatic logic [19:0] mk(int cb, bit s, bit l, bit f, bit c,
                                       logic [7:0] d);
        return {8'(cb), s, l, f, c, d};
    endfunction

    function automatic void build_exp(input int b);
        int          c, f, p, n, tot, k;
        bq_t         seg;
        logic [23:0] cr;
        c = (b + L - 1) / L;
        f = (c == 1) ? 0 : c * L - b;
        p = 0;
        exp_q.delete();
        for (int cb = 0; cb < c; cb++) begin
            seg.delete();
            n   = (c == 1) ? b : (cb == 0 ? L - f : L);
            tot = (cb == 0 ? f : 0) + n + (c > 1 ? 3 : 0);
            k   = 0;
            if (cb == 0) begin
                for (int i = 0; i < f; i++) begin
                    seg.push_back(8'h00);
                    exp_q.push_back(mk(cb, k == 0, k == tot - 1, 1, 0, 8'h00));
                    k++;
                end
            end
            for (int i = 0; i < n; i++) begin
                seg.push_back(src[p]);
                exp_q.push_back(mk(cb, k == 0, k == tot - 1, 0, 0, src[p]));
                p++;
                k++;
            end
            if (c > 1) begin
                cr = ref_crc(seg);
                exp_q.push_back(mk(cb, 0, 0, 0, 1, cr[23:16]));
                exp_q.push_back(mk(cb, 0, 0, 0, 1, cr[15:8]));
                exp_q.push_back(mk(cb, 0, 1, 0, 1, cr[7:0]));
            end
        end
    endfunction

    // Starts at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send_size(input int b);
        int guard = 0;
        size_in    = SW'(b);
        size_valid = 1'b1;
        #1;
        while (!size_ready && guard < 20) begin
            @(posedge clk); #2;
            guard++;
        end
        chk("size_accept", size_ready, 1);
        @(posedge clk); #1;
        size_valid = 1'b0;
        size_in    = '0;
    endtask

    task automatic run_tb(input int b, input bit stall, input int abort_at);
        int          ptr = 0, cyc = 0, lat = -1, c, budget;
        bit          hold = 0, prv = 0;
        logic [19:0] rec, prec;
        prec = '0;
        src.delete();
        for (int i = 0; i < b; i++) src.push_back(8'($urandom_range(0, 255)));
        build_exp(b);
        got_q.delete();
        c = (b + L - 1) / L;
        budget = exp_q.size() * 8 + 400;
        send_size(b);
        while (got_q.size() < exp_q.size() && cyc < budget) begin
            cyc++;
            if (ptr < b) begin
                s_data  = src[ptr];
                s_valid = (!stall || hold) ? 1'b1 : ($urandom_range(0, 2) != 0);
            end else begin
                s_data  = 8'hEE;
                s_valid = stall;
            end
            if (stall && $urandom_range(0, 9) >= 6) m_ready = 2'($urandom_range(0, 2));
            else                                    m_ready = 2'b11;
            #1;
            rec = {m_cb_idx, m_start, m_last, m_filler, m_crc, m_data};
            if (prv) chk("stall_hold", {m_valid, rec}, {1'b1, prec});
            if (m_valid && lat < 0) lat = cyc;
            if (m_valid && (&m_ready)) got_q.push_back(rec);
            prv  = m_valid && !(&m_ready);
            prec = rec;
            if (s_ready) ptr++;
            hold = s_valid && !s_ready;
            if (abort_at >= 0 && got_q.size() == abort_at) begin
                reset = 1'b1;
                #1;
                chk("async_reset_outputs",
                    {m_data, m_start, m_last, m_filler, m_crc, m_cb_idx, m_valid,
                     s_ready, size_ready, cb_count, busy, err}, '0);
                s_valid = 1'b0;
                m_ready = 2'b11;
                @(posedge clk); #1;
                reset = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        m_ready = 2'b11;
        chk("stream_len", got_q.size(), exp_q.size());
        foreach (exp_q[i])
            if (i < got_q.size()) chk($sformatf("byte%0d_B%0d", i, b), got_q[i], exp_q[i]);
        chk("cb_count", cb_count, c);
        chk("src_consumed", ptr, b);
        chk("busy_after", busy, 0);
        if (!stall) chk("latency", lat, c + 1);
    endtask

    initial begin
        int gcyc;
        bit seen;
        reset      = 1'b1;
        size_in    = '0;
        size_valid = 1'b1;
        s_data     = 8'h5A;
        s_valid    = 1'b1;
        m_ready    = 2'b11;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_outputs",
            {m_data, m_start, m_last, m_filler, m_crc, m_cb_idx, m_valid,
             s_ready, size_ready, cb_count, busy, err}, '0);
        size_valid = 1'b0;
        s_valid    = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        run_tb(10, 0, -1);
        run_tb(30, 0, -1);
        run_tb(26, 0, -1);
        run_tb(13, 0, -1);
        run_tb(14, 0, -1);
        run_tb(30, 1, -1);
        repeat (4) run_tb($urandom_range(1, 60), 1, -1);

        // zero-length TB, with excess source bytes offered
        s_valid = 1'b1;
        s_data  = 8'h77;
        send_size(0);
        #1;
        chk("zero_err", err, 1);
        chk("zero_busy", busy, 0);
        chk("zero_s_ready", s_ready, 0);
        @(posedge clk); #2;
        chk("zero_err_pulse", err, 0);
        chk("zero_busy2", busy, 0);
        chk("excess_s_ready", s_ready, 0);
        s_valid = 1'b0;
        @(posedge clk); #1;

        // C overflow: 3316 bytes needs 256 CBs of 13 payload bytes
        send_size(3316);
        gcyc = 0;
        seen = 0;
        while (!seen && gcyc < 400) begin
            #1;
            if (err) seen = 1;
            else begin
                @(posedge clk); #1;
                gcyc++;
            end
        end
        chk("ovf_err", seen, 1);
        chk("ovf_busy", busy, 0);
        @(posedge clk); #2;
        chk("ovf_err_pulse", err, 0);
        @(posedge clk); #1;

        run_tb(3315, 0, -1);

        run_tb(30, 0, 20);
        run_tb(10, 0, -1);
        run_tb(30, 1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cb_seg_stream.md
Name: cb_seg_stream

Overview:
- Parametrised next-generation code block segmentation engine for the turbo-encoder front end.
- Accepts transport-block (TB) bytes and the TB byte count over valid/ready handshakes.
- Splits the TB into C code blocks of K_BYTES each, with zero filler at the head of CB0 and a per-CB CRC appended when C>1.
- Broadcasts the output stream to N_OUT consumers (interleaver, encoder, ...) with a common valid and per-consumer ready.

Parameters:
- K_BYTES, 768, total code block length in bytes including the 3-byte CB CRC; must be >= 4.
- SIZE_W, 12, width of the TB byte count.
- N_OUT, 2, number of broadcast output consumers.
- CRC_POLY, 24'h800063, CB CRC generator polynomial without the x^24 term (gCRC24B).
- CNT_W, 8, width of the CB index/count.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- size_in  in  SIZE_W  TB length B in bytes
- size_valid  in  1  size_in valid
- size_ready  out  1  high in IDLE only
- s_data  in  8  TB byte
- s_valid  in  1  s_data valid
- s_ready  out  1  TB byte consumed this cycle
- m_data  out  8  output byte
- m_start  out  1  first byte of a CB
- m_last  out  1  last byte of a CB
- m_filler  out  1  byte is filler
- m_crc  out  1  byte is CB CRC
- m_cb_idx  out  CNT_W  index of the current CB
- m_valid  out  1  output byte valid
- m_ready  in  N_OUT  per-consumer ready
- cb_count  out  CNT_W  C of the current TB, held until the next size acceptance
- busy  out  1  high when the FSM is not in IDLE
- err  out  1  one-cycle pulse on B==0 or C overflow

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. It forces all outputs to 0 and the FSM to IDLE, clears all counters and the CRC register, and discards any in-flight TB. No partial CB completes after reset.
- Payload length: L = K_BYTES-3.
- Transfer rule: an output transfer occurs when m_valid and &m_ready. Outputs hold stable while m_valid is high and any ready is low. A consumer asserting ready alone does not advance the stream.
- IDLE:
  - size_ready=1.
  - On size_valid, latch B into rem, set C=1, and go to CALC.
  - If B==0, pulse err and stay in IDLE.
- CALC (one subtraction per cycle):
  - While rem>L: rem<=rem-L and C<=C+1.
  - If C would exceed 2^CNT_W-1, pulse err and return to IDLE.
  - When rem<=L, latch cb_count=C:
    - If C==1: F=0, CB length = B, no CRC.
    - Otherwise: F=L-rem.
  - Go to FILL if F>0, else go to DATA.
  - Latency from size acceptance to the first m_valid is ceil(B/L)+1 cycles.
- FILL (CB0 only):
  - Emit F bytes of 8'h00 with m_filler=1.
  - Filler bytes enter the CRC as zeros.
  - m_start=1 on the first filler byte.
- DATA:
  - m_valid=s_valid, m_data=s_data, s_ready=s_valid&&(&m_ready).
  - Byte count per CB: L-F for CB0, L for other CBs, B when C==1.
  - m_start is set on the first byte of a CB that has no filler.
  - For C==1, m_last is set on the final data byte and the FSM returns to IDLE.
  - Otherwise the FSM goes to CRC.
- CRC:
  - Emit crc[23:16], crc[15:8], crc[7:0] with m_crc=1; m_last=1 on the third byte.
  - The CRC register is cleared after the third byte.
  - If this was the last CB, return to IDLE; otherwise increment m_cb_idx and go to DATA.
- CRC computation: bytewise, MSB-first, init 0, computed over filler+data bytes of each CB. It updates only on transfer cycles, so it is stall-safe.
- Input stalls: s_valid low in DATA gives m_valid=0 with no state change.
- Excess TB bytes: not consumed (s_ready=0 outside DATA).
- Size back-to-back: size_ready rises the cycle after returning to IDLE. A new size is not accepted in the same cycle as the final m_last transfer.

Decomposition:
- Package cb_seg_pkg:
  - FSM state enum (IDLE, CALC, FILL, DATA, CRC).
  - CRC width constant 24.
  - Default polynomial constants for gCRC24A and gCRC24B.
- Sub-module cb_crc_byte: registered 24-bit bytewise CRC, parametrised by POLY.
  - Inputs: clk, reset, clr, en, d[7:0]. Output: crc[23:0].

Test Plan:
- K_BYTES=16, B=10, bytes 1..10 -> C=1; one CB of 10 bytes; m_start on byte 1, m_last on byte 10; no m_crc or m_filler.
- K_BYTES=16, B=30 -> C=3, F=9.
  - CB0: 9×00 (filler), bytes 1..4, 3 CRC bytes.
  - CB1: bytes 5..17 + CRC. CB2: bytes 18..30 + CRC.
  - CRC bytes must match the reference model of gCRC24B.
  - 48 output transfers in total.
- K_BYTES=16, B=26 -> C=2, F=0; CB0 starts directly with data byte 1 carrying m_start.
- B=30 with m_ready=2'b10 for 5 cycles mid-DATA and s_valid gaps -> output sequence identical to the unstalled run; no byte is duplicated or dropped.
- size_in=0 -> err pulses for 1 cycle; busy stays 0; s_ready stays 0.
- Assert reset during CB1 of B=30 -> all outputs 0 at once; then B=10 runs correctly with a fresh CRC and m_cb_idx=0.
